// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with loadable value and a time-multiplexed common-anode digit scanner.
// Latency: every output is registered; load, step and scan changes appear one edge after the inputs/ticks that cause them.
// Backpressure: none; free-running, with the count frozen by iEn=0 and the scanner always running.
module bcd_scan_counter #(
    parameter int STEP_DIV = 50000000,
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iEn,
    input  logic        iUp,
    input  logic        iLoad,
    input  logic [15:0] iLoadVal,
    output logic [3:0]  oDigit,
    output logic [3:0]  oAn,
    output logic [15:0] oCount,
    output logic        oWrap
);

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic [STEP_W-1:0] step_cnt, step_nxt;
    logic [SCAN_W-1:0] scan_cnt, scan_nxt;
    logic [1:0]        idx, idx_nxt;
    logic              an_on, an_on_nxt;
    logic [15:0]       count_nxt;
    logic              wrap_nxt;
    logic [3:0]        an_nxt;
    logic [3:0]        digit_nxt;
    logic              step_tick, scan_tick, blank;

    function automatic logic [15:0] bcd_sanitize(input logic [15:0] v);
        logic [15:0] r;
        for (int k = 0; k < 4; k++)
            r[4*k +: 4] = (v[4*k +: 4] > 4'd9) ? 4'd0 : v[4*k +: 4];
        return r;
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (carry) begin
                if (r[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = r[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (borrow) begin
                if (r[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = r[4*k +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign step_tick = iEn && (step_cnt == STEP_LAST);
    assign scan_tick = (scan_cnt == SCAN_LAST);

    always_comb begin
        count_nxt = oCount;
        wrap_nxt  = 1'b0;
        step_nxt  = step_cnt;
        if (iLoad) begin
            count_nxt = bcd_sanitize(iLoadVal);
            step_nxt  = '0;
        end else if (step_tick) begin
            step_nxt = '0;
            if (iUp) begin
                count_nxt = bcd_inc(oCount);
                wrap_nxt  = (oCount == 16'h9999);
            end else begin
                count_nxt = bcd_dec(oCount);
                wrap_nxt  = (oCount == 16'h0000);
            end
        end else if (iEn) begin
            step_nxt = step_cnt + STEP_W'(1);
        end
    end

    // Digit select and nibble are both derived from the post-update count and index,
    // so the anode and the segment data always switch together.
    always_comb begin
        scan_nxt  = scan_tick ? '0 : scan_cnt + SCAN_W'(1);
        idx_nxt   = scan_tick ? idx + 2'd1 : idx;
        an_on_nxt = an_on | scan_tick;
        case (idx_nxt)
            2'd1:    blank = (count_nxt[15:4] == 12'h000);
            2'd2:    blank = (count_nxt[15:8] == 8'h00);
            2'd3:    blank = (count_nxt[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
        an_nxt = 4'b1111;
        if (an_on_nxt && !(BLANK_LZ && blank))
            an_nxt[idx_nxt] = 1'b0;
        digit_nxt = count_nxt[{idx_nxt, 2'b00} +: 4];
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            oCount   <= 16'h0000;
            oDigit   <= 4'd0;
            oAn      <= 4'b1111;
            oWrap    <= 1'b0;
            step_cnt <= '0;
            scan_cnt <= '0;
            idx      <= 2'd3;
            an_on    <= 1'b0;
        end else begin
            oCount   <= count_nxt;
            oDigit   <= digit_nxt;
            oAn      <= an_nxt;
            oWrap    <= wrap_nxt;
            step_cnt <= step_nxt;
            scan_cnt <= scan_nxt;
            idx      <= idx_nxt;
            an_on    <= an_on_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: one unblanked and one blanking instance driven in parallel.
// A decimal reference model pushes expected outputs per cycle; a monitor pops and compares after each edge.
// Backpressure: none.
module tb_bcd_scan_counter;

    localparam int STEP_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic        iClk = 1'b0;
    logic        iRst_n, iEn, iUp, iLoad;
    logic [15:0] iLoadVal;
    logic [3:0]  dig0, an0, dig1, an1;
    logic [15:0] cnt0, cnt1;
    logic        wrap0, wrap1;

    always #5 iClk = ~iClk;

    bcd_scan_counter #(.STEP_DIV(STEP_DIV), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) u_plain (
        .iClk(iClk), .iRst_n(iRst_n), .iEn(iEn), .iUp(iUp), .iLoad(iLoad), .iLoadVal(iLoadVal),
        .oDigit(dig0), .oAn(an0), .oCount(cnt0), .oWrap(wrap0));

    bcd_scan_counter #(.STEP_DIV(STEP_DIV), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) u_blank (
        .iClk(iClk), .iRst_n(iRst_n), .iEn(iEn), .iUp(iUp), .iLoad(iLoad), .iLoadVal(iLoadVal),
        .oDigit(dig1), .oAn(an1), .oCount(cnt1), .oWrap(wrap1));

    typedef struct packed {
        logic [15:0] cnt;
        logic [3:0]  dig;
        logic [3:0]  an_plain;
        logic [3:0]  an_blank;
        logic        wrap;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   wrap_seen = 0;

    // Reference model state, kept in plain decimal.
    int m_cnt = 0, m_step = 0, m_scan = 0, m_idx = 3;
    bit m_on = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int load_dec(input logic [15:0] v);
        int r, w;
        logic [3:0] n;
        r = 0;
        w = 1;
        for (int k = 0; k < 4; k++) begin
            n = v[4*k +: 4];
            if (n <= 4'd9) r += int'(n) * w;
            w *= 10;
        end
        return r;
    endfunction

    function automatic int pow10(input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) r *= 10;
        return r;
    endfunction

    // Advance the model by one clock with the inputs currently driven, and queue the expectation.
    task automatic model_push();
        exp_t e;
        bit   tick, wrap;
        wrap = 0;
        if (!iRst_n) begin
            m_cnt = 0; m_step = 0; m_scan = 0; m_idx = 3; m_on = 0;
        end else begin
            tick = iEn && (m_step == STEP_DIV - 1);
            if (iLoad) begin
                m_cnt  = load_dec(iLoadVal);
                m_step = 0;
            end else if (tick) begin
                m_step = 0;
                if (iUp) begin
                    wrap  = (m_cnt == 9999);
                    m_cnt = (m_cnt + 1) % 10000;
                end else begin
                    wrap  = (m_cnt == 0);
                    m_cnt = (m_cnt + 9999) % 10000;
                end
            end else if (iEn) begin
                m_step++;
            end
            if (m_scan == SCAN_DIV - 1) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % 4;
                m_on   = 1;
            end else begin
                m_scan++;
            end
        end
        e.cnt      = to_bcd(m_cnt);
        e.wrap     = wrap;
        e.dig      = iRst_n ? 4'((m_cnt / pow10(m_idx)) % 10) : 4'd0;
        e.an_plain = m_on ? ~(4'b0001 << m_idx) : 4'b1111;
        e.an_blank = (m_on && !(m_idx >= 1 && m_cnt < pow10(m_idx))) ? ~(4'b0001 << m_idx) : 4'b1111;
        sb.push_back(e);
    endtask

    always @(posedge iClk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("count",      32'(cnt0),  32'(e.cnt));
            check("digit",      32'(dig0),  32'(e.dig));
            check("an",         32'(an0),   32'(e.an_plain));
            check("wrap",       32'(wrap0), 32'(e.wrap));
            check("blk_count",  32'(cnt1),  32'(e.cnt));
            check("blk_digit",  32'(dig1),  32'(e.dig));
            check("blk_an",     32'(an1),   32'(e.an_blank));
            if (wrap0) wrap_seen++;
        end
    end

    task automatic cyc(input bit rst_n, input bit en, input bit up, input bit ld, input logic [15:0] val);
        @(negedge iClk);
        iRst_n   = rst_n;
        iEn      = en;
        iUp      = up;
        iLoad    = ld;
        iLoadVal = val;
        model_push();
        @(posedge iClk);
        #2;
    endtask

    task automatic run(input int n, input bit en, input bit up);
        for (int i = 0; i < n; i++) cyc(1'b1, en, up, 1'b0, 16'h0000);
    endtask

    initial begin
        iRst_n = 1'b0; iEn = 1'b1; iUp = 1'b1; iLoad = 1'b0; iLoadVal = 16'h0000;

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        check("rst_count", 32'(cnt0), 32'h0);
        check("rst_an",    32'(an0),  32'hF);
        run(2, 1'b0, 1'b1);
        check("first_scan_an", 32'(an0), 32'hE);

        // Up count through the 9999 -> 0000 wrap.
        wrap_seen = 0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h9998);
        run(4, 1'b1, 1'b1);
        check("up_9999", 32'(cnt0), 32'h9999);
        run(4, 1'b1, 1'b1);
        check("up_wrap_val", 32'(cnt0), 32'h0000);
        run(6, 1'b1, 1'b1);
        check("up_wrap_pulses", 32'(wrap_seen), 32'd1);

        // Down count with borrow, then the 0000 -> 9999 wrap.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h1000);
        run(4, 1'b1, 1'b0);
        check("down_borrow", 32'(cnt0), 32'h0999);
        wrap_seen = 0;
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
        run(4, 1'b1, 1'b0);
        check("down_wrap_val", 32'(cnt0), 32'h9999);
        check("down_wrap_pulses", 32'(wrap_seen), 32'd1);

        // Load arriving in the step-tick cycle wins and restarts the prescaler.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
        run(3, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h12A4);
        check("collide_count", 32'(cnt0),  32'h1204);
        check("collide_wrap",  32'(wrap0), 32'h0);
        run(3, 1'b1, 1'b1);
        check("collide_restart", 32'(cnt0), 32'h1204);
        run(1, 1'b1, 1'b1);
        check("collide_next_step", 32'(cnt0), 32'h1205);

        // Frozen count while the scanner walks the digits.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h4321);
        run(10, 1'b0, 1'b1);
        check("scan_frozen", 32'(cnt0), 32'h4321);

        // Leading-zero blanking cases.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0040);
        run(8, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
        run(8, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF);
        check("load_all_invalid", 32'(cnt0), 32'h0000);

        // Mid-operation reset after a pending wrap.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h9999);
        run(4, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        check("midrst_wrap", 32'(wrap0), 32'h0);
        check("midrst_an",   32'(an0),   32'hF);

        // Random traffic, including invalid load nibbles and occasional resets.
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0), 16'($urandom));

        @(negedge iClk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
